mux_tree_pipe: RTL

- Parametrised, pipelined N:1 multiplexer tree built from radix-4 select levels.
- Successor to the fixed 16:1 combinational tree: configurable data width and input count, with one register stage per tree level.
- Valid/ready handshake with full backpressure.
- Sits between wide parallel sources and a single serial consumer, for example channel scanning or debug-bus selection.

---
 rtl/mux_tree_pipe_pkg.sv | 14 +
 rtl/mux4_stage.sv | 41 ++++
 rtl/mux_tree_pipe.sv | 61 ++++++
 3 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// mux_tree_pipe_pkg: radix constants and tree-sizing helpers shared by the mux tree
package mux_tree_pipe_pkg;
  localparam int MUX_RADIX = 4;
  localparam int RADIX_BITS = 2;
  function automatic int log4(input int n);
    int r;
    r = 0;
    for (int v = n; v > 1; v = v / MUX_RADIX) r++;
    return r;
  endfunction
  function automatic bit is_pow4(input int n);
    return n >= MUX_RADIX && (1 << (RADIX_BITS * log4(n))) == n;
  endfunction
endpackage

// File: rtl/mux4_stage.sv
// mux4_stage: one registered radix-4 level of the select tree with valid/advance control
module mux4_stage
  import mux_tree_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GROUPS = 4,
  parameter int SEL_W = 4,
  parameter int LVL = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [GROUPS*MUX_RADIX*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]                 in_sel,
  input  logic                             in_valid,
  input  logic                             adv_next,
  output logic                             adv,
  output logic [GROUPS*DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]                 out_sel,
  output logic                             out_valid
);
  logic [RADIX_BITS-1:0] pick;
  logic [GROUPS*DATA_W-1:0] nxt;
  assign pick = in_sel[RADIX_BITS*LVL +: RADIX_BITS];
  assign adv = !out_valid || adv_next;
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    assign nxt[g*DATA_W +: DATA_W] = in_data[(g*MUX_RADIX + int'(pick))*DATA_W +: DATA_W];
  end
  // load on advance; data and select only capture real items to avoid needless toggling
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= nxt;
        out_sel <= in_sel;
      end
    end
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 radix-4 mux tree with valid/ready backpressure
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 16,
  localparam int LEVELS = log4(NUM_IN),
  localparam int SEL_W = RADIX_BITS * LEVELS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);
  logic [LEVELS:0] adv;
  logic [LEVELS:0] vld;
  logic [LEVELS:0][SEL_W-1:0] sel;
  if (!is_pow4(NUM_IN)) begin : g_bad_num_in
    $error("mux_tree_pipe: NUM_IN=%0d is not a power of 4", NUM_IN);
  end
  assign adv[LEVELS] = out_ready;
  assign in_ready = adv[0];
  assign vld[0] = in_valid;
  assign sel[0] = in_sel;
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int GROUPS = NUM_IN >> (RADIX_BITS * (k + 1));
    logic [GROUPS*MUX_RADIX*DATA_W-1:0] d;
    logic [GROUPS*DATA_W-1:0] q;
    if (k == 0) begin : g_src
      assign d = in_data;
    end else begin : g_src
      assign d = g_lvl[k-1].q;
    end
    mux4_stage #(
      .DATA_W(DATA_W),
      .GROUPS(GROUPS),
      .SEL_W(SEL_W),
      .LVL(k)
    ) u_stage (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(d),
      .in_sel(sel[k]),
      .in_valid(vld[k]),
      .adv_next(adv[k+1]),
      .adv(adv[k]),
      .out_data(q),
      .out_sel(sel[k+1]),
      .out_valid(vld[k+1])
    );
  end
  assign out_data = g_lvl[LEVELS-1].q;
  assign out_sel = sel[LEVELS];
  assign out_valid = vld[LEVELS];
endmodule
